// File: rtl/exp_arbiter.sv
// Exception arbiter/sequencer: edge-captured pending sources, masked selection,
// redirect handshake, EPC strobe and single in-service hold. EXP_RR_EN selects round-robin.
module exp_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  exp_src,
    input  logic [2:0]  blk_mask,
    input  logic        glob_block,
    input  logic [31:0] pc_cur,
    input  logic        exp_ack,
    input  logic        eret,
    output logic        exp_req,
    output logic [1:0]  exp_id,
    output logic [31:0] cause,
    output logic        epc_we,
    output logic [31:0] epc_val,
    output logic        in_service,
    output logic [2:0]  pending
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  src_q_r;
    logic [2:0]  pend_r;
    logic        exp_req_r;
    logic [1:0]  exp_id_r;
    logic [31:0] cause_r;
    logic        epc_we_r;
    logic [31:0] epc_val_r;
    logic        in_service_r;

    logic [2:0]  rise_s;
    logic [2:0]  elig_s;
    logic [2:0]  clr_s;
    logic [2:0]  pend_nxt_s;
    logic        grant_s;
    logic        ack_s;
    logic [1:0]  pick_s;

    function automatic logic [31:0] cause_of(input logic [1:0] id);
        logic [31:0] c;
        case (id)
            2'd0:    c = 32'h0000_0001;
            2'd1:    c = 32'h0000_0003;
            2'd2:    c = 32'h0000_0007;
            default: c = 32'h0000_0000;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] onehot_of(input logic [1:0] id);
        logic [2:0] oh;
        case (id)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] pick_fixed(input logic [2:0] el);
        logic [1:0] p;
        if (el[0]) begin
            p = 2'd0;
        end else if (el[1]) begin
            p = 2'd1;
        end else begin
            p = 2'd2;
        end
        return p;
    endfunction

    // Edge detection, eligibility and pending update; a new rise beats a same-cycle clear.
    always_comb begin
        rise_s  = exp_src & ~src_q_r;
        elig_s  = pend_r & ~blk_mask;
        ack_s   = (state_r == ST_REQ) && exp_ack;
        grant_s = (state_r == ST_IDLE) && !glob_block && (elig_s != 3'b000);
        if (ack_s) begin
            clr_s = onehot_of(exp_id_r);
        end else begin
            clr_s = 3'b000;
        end
        pend_nxt_s = (pend_r & ~clr_s) | rise_s;
    end

`ifdef EXP_RR_EN
    logic [1:0] rr_ptr_r;

    function automatic logic [1:0] pick_rr(input logic [2:0] el, input logic [1:0] ptr);
        logic [1:0] p;
        case (ptr)
            2'd1:    p = el[1] ? 2'd1 : (el[2] ? 2'd2 : 2'd0);
            2'd2:    p = el[2] ? 2'd2 : (el[0] ? 2'd0 : 2'd1);
            default: p = pick_fixed(el);
        endcase
        return p;
    endfunction

    // Round-robin selection starting at the pointer.
    always_comb begin
        pick_s = pick_rr(elig_s, rr_ptr_r);
    end

    // Pointer advances past the source whose grant was acknowledged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_r <= 2'd0;
        end else if (ack_s) begin
            case (exp_id_r)
                2'd0:    rr_ptr_r <= 2'd1;
                2'd1:    rr_ptr_r <= 2'd2;
                default: rr_ptr_r <= 2'd0;
            endcase
        end
    end
`else
    // Fixed priority selection: source 0 first.
    always_comb begin
        pick_s = pick_fixed(elig_s);
    end
`endif

    // Sequencer FSM with registered outputs; id, cause and EPC stay frozen after a grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            src_q_r      <= 3'b111;
            pend_r       <= 3'b000;
            exp_req_r    <= 1'b0;
            exp_id_r     <= 2'd0;
            cause_r      <= 32'h0000_0000;
            epc_we_r     <= 1'b0;
            epc_val_r    <= 32'h0000_0000;
            in_service_r <= 1'b0;
        end else begin
            src_q_r  <= exp_src;
            pend_r   <= pend_nxt_s;
            epc_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r   <= ST_REQ;
                        exp_req_r <= 1'b1;
                        exp_id_r  <= pick_s;
                        cause_r   <= cause_of(pick_s);
                        epc_val_r <= pc_cur;
                    end
                end
                ST_REQ: begin
                    if (exp_ack) begin
                        state_r      <= ST_SERVE;
                        exp_req_r    <= 1'b0;
                        epc_we_r     <= 1'b1;
                        in_service_r <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (eret) begin
                        state_r      <= ST_IDLE;
                        in_service_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    exp_req_r    <= 1'b0;
                    in_service_r <= 1'b0;
                end
            endcase
        end
    end

    assign exp_req    = exp_req_r;
    assign exp_id     = exp_id_r;
    assign cause      = cause_r;
    assign epc_we     = epc_we_r;
    assign epc_val    = epc_val_r;
    assign in_service = in_service_r;
    assign pending    = pend_r;

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed self-checking bench for exp_arbiter; expectations are hand-computed per scenario.
module tb_exp_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  exp_src;
    logic [2:0]  blk_mask;
    logic        glob_block;
    logic [31:0] pc_cur;
    logic        exp_ack;
    logic        eret;
    logic        exp_req;
    logic [1:0]  exp_id;
    logic [31:0] cause;
    logic        epc_we;
    logic [31:0] epc_val;
    logic        in_service;
    logic [2:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    exp_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .exp_src    (exp_src),
        .blk_mask   (blk_mask),
        .glob_block (glob_block),
        .pc_cur     (pc_cur),
        .exp_ack    (exp_ack),
        .eret       (eret),
        .exp_req    (exp_req),
        .exp_id     (exp_id),
        .cause      (cause),
        .epc_we     (epc_we),
        .epc_val    (epc_val),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; exp_src = 3'b000; blk_mask = 3'b000; glob_block = 1'b0;
        pc_cur = 32'h0; exp_ack = 1'b0; eret = 1'b0;
        tick(); tick();
        n_checks++;
        if ({exp_req, exp_id, epc_we, in_service, pending} !== 8'h00 || cause !== 32'h0 || epc_val !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b id=%0d cause=%h we=%b epc=%h svc=%b pend=%b, required all 0",
                     exp_req, exp_id, cause, epc_we, epc_val, in_service, pending);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        pc_cur = 32'h0000_0040; exp_src = 3'b010;
        tick();
        n_checks++;
        if (pending !== 3'b010 || exp_req !== 1'b0) begin
            n_fail++; $display("FAIL single_pend: pend=%b req=%b, required 010 0", pending, exp_req);
        end
        tick();
        pc_cur = 32'h0000_0099;
        n_checks++;
        if (exp_req !== 1'b1 || exp_id !== 2'd1 || cause !== 32'h3 || epc_val !== 32'h40) begin
            n_fail++; $display("FAIL single_grant: req=%b id=%0d cause=%h epc=%h, required 1 1 3 40", exp_req, exp_id, cause, epc_val);
        end
        exp_ack = 1'b1; tick(); exp_ack = 1'b0;
        n_checks++;
        if (epc_we !== 1'b1 || in_service !== 1'b1 || exp_req !== 1'b0 || epc_val !== 32'h40 || pending !== 3'b000) begin
            n_fail++; $display("FAIL single_ack: we=%b svc=%b req=%b epc=%h pend=%b, required 1 1 0 40 000",
                               epc_we, in_service, exp_req, epc_val, pending);
        end
        tick();
        n_checks++;
        if (epc_we !== 1'b0 || in_service !== 1'b1) begin
            n_fail++; $display("FAIL single_we_width: we=%b svc=%b, required 0 1", epc_we, in_service);
        end
        eret = 1'b1; tick(); eret = 1'b0;
        n_checks++;
        if (in_service !== 1'b0 || cause !== 32'h3 || exp_id !== 2'd1 || epc_val !== 32'h40) begin
            n_fail++; $display("FAIL single_eret: svc=%b cause=%h id=%0d epc=%h, required 0 3 1 40", in_service, cause, exp_id, epc_val);
        end
        exp_src = 3'b000; tick();
    endtask

    task automatic test_burst();
        logic [31:0] exp_cause [3];
        logic [2:0]  exp_pend  [3];
        exp_cause[0] = 32'h1; exp_cause[1] = 32'h3; exp_cause[2] = 32'h7;
        exp_pend[0] = 3'b110; exp_pend[1] = 3'b100; exp_pend[2] = 3'b000;
        reset = 1'b0; tick(); reset = 1'b1; tick();
        exp_src = 3'b111; tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (exp_req !== 1'b1 || exp_id !== i[1:0] || cause !== exp_cause[i]) begin
                n_fail++; $display("FAIL burst_grant%0d: req=%b id=%0d cause=%h, required 1 %0d %h", i, exp_req, exp_id, cause, i, exp_cause[i]);
            end
            exp_ack = 1'b1; tick(); exp_ack = 1'b0;
            n_checks++;
            if (pending !== exp_pend[i] || in_service !== 1'b1) begin
                n_fail++; $display("FAIL burst_ack%0d: pend=%b svc=%b, required %b 1", i, pending, in_service, exp_pend[i]);
            end
            eret = 1'b1; tick(); eret = 1'b0;
        end
        exp_src = 3'b000; tick();
    endtask

    task automatic test_rotation();
        logic [1:0] want;
`ifdef EXP_RR_EN
        want = 2'd1;
`else
        want = 2'd0;
`endif
        exp_src = 3'b001; tick(); tick();
        n_checks++;
        if (exp_req !== 1'b1 || exp_id !== 2'd0) begin
            n_fail++; $display("FAIL rot_first: req=%b id=%0d, required 1 0", exp_req, exp_id);
        end
        exp_ack = 1'b1; tick(); exp_ack = 1'b0;
        exp_src = 3'b000; tick();
        exp_src = 3'b011; tick();
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        n_checks++;
        if (exp_req !== 1'b1 || exp_id !== want) begin
            n_fail++; $display("FAIL rot_second: req=%b id=%0d, required 1 %0d", exp_req, exp_id, want);
        end
        exp_ack = 1'b1; tick(); exp_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        exp_ack = 1'b1; tick(); exp_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        exp_src = 3'b000; tick();
        n_checks++;
        if (pending !== 3'b000 || exp_req !== 1'b0) begin
            n_fail++; $display("FAIL rot_drain: pend=%b req=%b, required 000 0", pending, exp_req);
        end
    endtask

    task automatic test_mask();
        blk_mask = 3'b001; exp_src = 3'b001;
        tick(); tick(); tick();
        n_checks++;
        if (pending !== 3'b001 || exp_req !== 1'b0) begin
            n_fail++; $display("FAIL mask_hold: pend=%b req=%b, required 001 0", pending, exp_req);
        end
        blk_mask = 3'b000; tick();
        n_checks++;
        if (exp_req !== 1'b1 || exp_id !== 2'd0 || cause !== 32'h1) begin
            n_fail++; $display("FAIL mask_release: req=%b id=%0d cause=%h, required 1 0 1", exp_req, exp_id, cause);
        end
        exp_ack = 1'b1; tick(); exp_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        exp_src = 3'b000; tick();
    endtask

    task automatic test_glob_block();
        glob_block = 1'b1; exp_src = 3'b100;
        tick(); tick(); tick();
        n_checks++;
        if (pending !== 3'b100 || exp_req !== 1'b0) begin
            n_fail++; $display("FAIL gblock_hold: pend=%b req=%b, required 100 0", pending, exp_req);
        end
        glob_block = 1'b0; tick();
        n_checks++;
        if (exp_req !== 1'b1 || exp_id !== 2'd2 || cause !== 32'h7) begin
            n_fail++; $display("FAIL gblock_grant: req=%b id=%0d cause=%h, required 1 2 7", exp_req, exp_id, cause);
        end
        glob_block = 1'b1; blk_mask = 3'b100; tick(); tick();
        n_checks++;
        if (exp_req !== 1'b1 || exp_id !== 2'd2) begin
            n_fail++; $display("FAIL gblock_keep_req: req=%b id=%0d, required 1 2", exp_req, exp_id);
        end
        exp_ack = 1'b1; tick(); exp_ack = 1'b0;
        n_checks++;
        if (epc_we !== 1'b1 || in_service !== 1'b1 || pending !== 3'b000) begin
            n_fail++; $display("FAIL gblock_ack: we=%b svc=%b pend=%b, required 1 1 000", epc_we, in_service, pending);
        end
        glob_block = 1'b0; blk_mask = 3'b000;
        eret = 1'b1; tick(); eret = 1'b0;
        exp_src = 3'b000; tick();
    endtask

    task automatic test_stray_and_reset();
        eret = 1'b1; exp_ack = 1'b1; tick(); eret = 1'b0; exp_ack = 1'b0;
        n_checks++;
        if (exp_req !== 1'b0 || in_service !== 1'b0 || epc_we !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: req=%b svc=%b we=%b, required 0 0 0", exp_req, in_service, epc_we);
        end
        pc_cur = 32'h0000_0123; exp_src = 3'b010; tick(); tick();
        eret = 1'b1; tick(); eret = 1'b0;
        n_checks++;
        if (exp_req !== 1'b1 || in_service !== 1'b0 || epc_val !== 32'h123) begin
            n_fail++; $display("FAIL stray_eret_req: req=%b svc=%b epc=%h, required 1 0 123", exp_req, in_service, epc_val);
        end
        exp_ack = 1'b1; tick(); tick(); exp_ack = 1'b0;
        n_checks++;
        if (in_service !== 1'b1 || epc_we !== 1'b0 || exp_req !== 1'b0) begin
            n_fail++; $display("FAIL stray_ack_serve: svc=%b we=%b req=%b, required 1 0 0", in_service, epc_we, exp_req);
        end
        reset = 1'b0; tick(); reset = 1'b1;
        n_checks++;
        if ({exp_req, exp_id, epc_we, in_service, pending} !== 8'h00 || cause !== 32'h0 || epc_val !== 32'h0) begin
            n_fail++; $display("FAIL reset_in_serve: req=%b id=%0d cause=%h we=%b epc=%h svc=%b pend=%b, required all 0",
                               exp_req, exp_id, cause, epc_we, epc_val, in_service, pending);
        end
        tick(); tick(); tick();
        n_checks++;
        if (pending !== 3'b000 || exp_req !== 1'b0 || epc_we !== 1'b0) begin
            n_fail++; $display("FAIL high_at_release: pend=%b req=%b we=%b, required 000 0 0", pending, exp_req, epc_we);
        end
        exp_src = 3'b000; tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_rotation();
        test_mask();
        test_glob_block();
        test_stray_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_arbiter.md
# exp_arbiter

Exception arbiter and sequencer for the coprocessor-0 exception path. It captures rising edges on the three exception sources and holds them as pending. It then selects one eligible source against the per-source block mask and the global block bit, and handshakes a redirect request with the core. It produces the cause code and EPC write strobe, then holds the in-service state until `eret` retires, so only one exception is serviced at a time.

## Interface
- No parameters; source count fixed at 3.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `exp_src`  in  3  raw exception source levels; a 0→1 transition between samples is one event.
- `blk_mask`  in  3  per-source block; 1 = source ineligible, pending bit retained.
- `glob_block`  in  1  Status[0]; 1 = no new grant from IDLE.
- `pc_cur`  in  32  PC of the instruction in execution.
- `exp_ack`  in  1  core accepts redirect; sampled only in REQ.
- `eret`  in  1  one-cycle pulse, eret retired; sampled only in SERVE.
- `exp_req`  out  1  redirect request, high throughout REQ.
- `exp_id`  out  2  granted source index 0..2, valid from REQ until the next grant.
- `cause`  out  32  cause code: src0 = 32'h1, src1 = 32'h3, src2 = 32'h7.
- `epc_we`  out  1  one-cycle EPC write strobe.
- `epc_val`  out  32  PC captured at grant.
- `in_service`  out  1  high in SERVE.
- `pending`  out  3  pending event bits.

## Operation
- Edge capture: `src_q` holds the previous sample. `pend[i]` sets when `exp_src[i] & ~src_q[i]`. Set wins over a same-cycle clear of the same bit.
- Eligibility: `elig = pend & ~blk_mask`. A grant occurs only in IDLE with `glob_block == 0` and `elig != 0`.
- Fixed priority: source 0 highest, source 2 lowest.
- FSM states: IDLE, REQ, SERVE.
- IDLE → REQ on grant. Latch `exp_id`, `cause` and `epc_val <= pc_cur` on that edge.
- REQ: hold `exp_req = 1`.
  - The latched id, cause and EPC are frozen.
  - Raising `glob_block` or `blk_mask` does not withdraw the request.
  - On sampled `exp_ack`: clear `pend[exp_id]`, pulse `epc_we` the next cycle, go to SERVE.
- SERVE: `in_service = 1`. New edges still set pending bits. On sampled `eret`, go to IDLE.
- `eret` outside SERVE and `exp_ack` outside REQ are ignored.
- Outputs `cause`, `exp_id` and `epc_val` retain their last value after SERVE.

## Timing
- Reset (`reset == 0` at an edge):
  - state IDLE;
  - `pend = 0`, `src_q = 3'b111`, so sources already high at reset release are not events;
  - all outputs 0, including `cause`, `epc_val` and `exp_id`.
- Reset overrides any state mid-operation, including REQ or SERVE. No `epc_we` is issued after reset.
- Latency, with source rise sampled at edge N:
  - `pend` visible after edge N;
  - grant at edge N+1, so `exp_req` is high in cycle N+1;
  - `exp_ack` sampled high at edge M moves the FSM to SERVE, with `epc_we` and `in_service` high in cycle M.
- `epc_we` is exactly one cycle wide, once per acked grant.
- Minimum IDLE→IDLE loop is 3 edges: grant, ack, eret. The next grant needs one more edge in IDLE.
- If a blocked source becomes unblocked, it is eligible in the same cycle `blk_mask` falls.

## Configuration
- `EXP_RR_EN`
  - Defined: round-robin arbitration. A 2-bit pointer starts at 0 after reset. Search order begins at the pointer; after each acked grant the pointer becomes `exp_id + 1` mod 3.
  - Undefined: fixed priority 0 > 1 > 2, with no pointer logic.
- `cause` encoding is identical in both modes.

## Test plan
- Single event: reset low for 2 cycles, then `exp_src = 3'b010` rise with `pc_cur = 32'h0000_0040`.
  - Expected: `exp_req` 1 edge after `pend`, `cause = 32'h3`, `exp_id = 1`.
  - After ack: `epc_we` pulse with `epc_val = 32'h40`, then `in_service = 1` until `eret`.
- Simultaneous `exp_src` 3'b111 rise:
  - Fixed priority: grants in order 0, 1, 2 with causes 1, 3, 7, each after `eret`.
  - `EXP_RR_EN` defined: the same order from reset, then rotation verified on a second burst.
- Mask: `blk_mask = 3'b001` with src0 rising.
  - Expected: `pending = 3'b001`, no `exp_req`.
  - Clearing the mask yields a grant on the next edge.
- Global block: `glob_block = 1` blocks the grant from IDLE.
  - Raising `glob_block` during REQ keeps `exp_req` high until ack.
- Stray strobes and mid-service reset:
  - `eret` in IDLE or REQ, or `exp_ack` in IDLE or SERVE: no state change.
  - Source already high when reset deasserts: no event.
  - Reset during SERVE: all outputs 0 next cycle.
